// File: rtl/half_adder_dfa_seq.sv
// Clocked half adder / bit-serial adder with a two-state carry DFA.
// Optional HA_STICKY_CARRY_EN adds a registered sticky carry_seen flag.
module half_adder_dfa_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             mode,
    input  logic             clear_carry,
    output logic             s,
    output logic             c,
    output logic             out_valid,
    output logic             carry_state,
`ifdef HA_STICKY_CARRY_EN
    output logic             carry_seen,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        S_C0 = 1'b0,
        S_C1 = 1'b1
    } carry_state_t;

    carry_state_t state;
    logic         cin;
    logic         sum_next;
    logic         carry_next;

    assign carry_state = state;

    // In half-add mode the stored carry is ignored entirely.
    always_comb begin
        cin        = clear_carry ? 1'b0 : (state == S_C1);
        sum_next   = a ^ b;
        carry_next = a & b;
        if (mode) begin
            sum_next   = a ^ b ^ cin;
            carry_next = (a & b) | (a & cin) | (b & cin);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= 1'b0;
            c         <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_C0;
            bit_cnt   <= '0;
`ifdef HA_STICKY_CARRY_EN
            carry_seen <= 1'b0;
`endif
        end else if (in_valid) begin
            out_valid <= 1'b1;
            s         <= sum_next;
            c         <= carry_next;
            if (mode) begin
                state   <= carry_next ? S_C1 : S_C0;
                bit_cnt <= (clear_carry ? '0 : bit_cnt) + CNT_W'(1);
            end else begin
                state   <= S_C0;
                bit_cnt <= '0;
            end
`ifdef HA_STICKY_CARRY_EN
            if (carry_next)
                carry_seen <= 1'b1;
            else if (clear_carry)
                carry_seen <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_half_adder_dfa_seq.sv
// Self-checking bench for half_adder_dfa_seq: directed scenarios plus random beats
// checked against an arithmetic reference model (sum = a + b + carry-in).
module tb_half_adder_dfa_seq;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b1;
    logic             a = 1'b1;
    logic             b = 1'b1;
    logic             mode = 1'b0;
    logic             clear_carry = 1'b0;
    logic             s;
    logic             c;
    logic             out_valid;
    logic             carry_state;
    logic [CNT_W-1:0] bit_cnt;
`ifdef HA_STICKY_CARRY_EN
    logic             carry_seen;
`endif

    int checks = 0;
    int errors = 0;

    int m_s = 0;
    int m_c = 0;
    int m_ov = 0;
    int m_carry = 0;
    int m_cnt = 0;
    int m_seen = 0;

    half_adder_dfa_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .mode(mode),
        .clear_carry(clear_carry),
        .s(s),
        .c(c),
        .out_valid(out_valid),
        .carry_state(carry_state),
`ifdef HA_STICKY_CARRY_EN
        .carry_seen(carry_seen),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".s"}, int'(s), m_s);
        checkOutput({tag, ".c"}, int'(c), m_c);
        checkOutput({tag, ".out_valid"}, int'(out_valid), m_ov);
        checkOutput({tag, ".carry_state"}, int'(carry_state), m_carry);
        checkOutput({tag, ".bit_cnt"}, int'(bit_cnt), m_cnt);
`ifdef HA_STICKY_CARRY_EN
        checkOutput({tag, ".carry_seen"}, int'(carry_seen), m_seen);
`endif
    endtask

    // Drive one cycle of inputs, advance the reference model, then compare.
    task automatic applyStimulus(input logic v, input logic ai, input logic bi,
                                 input logic md, input logic cc, input logic rn,
                                 input string tag);
        int cin;
        int total;
        @(negedge clk);
        in_valid    = v;
        a           = ai;
        b           = bi;
        mode        = md;
        clear_carry = cc;
        rst_n       = rn;
        @(posedge clk);
        if (!rn) begin
            m_s = 0; m_c = 0; m_ov = 0; m_carry = 0; m_cnt = 0; m_seen = 0;
        end else if (v) begin
            cin = cc ? 0 : m_carry;
            total = int'(ai) + int'(bi) + (md ? cin : 0);
            m_s  = total % 2;
            m_c  = total / 2;
            m_ov = 1;
            if (md) begin
                m_carry = m_c;
                m_cnt   = ((cc ? 0 : m_cnt) + 1) % (1 << CNT_W);
            end else begin
                m_carry = 0;
                m_cnt   = 0;
            end
            if (m_c == 1) m_seen = 1;
            else if (cc) m_seen = 0;
        end else begin
            m_ov = 0;
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        int serial_sum;
        int v, ai, bi, md, cc, rn;

        applyStimulus(1, 1, 1, 0, 0, 0, "reset0");
        applyStimulus(1, 1, 1, 0, 0, 0, "reset1");
        checkOutput("reset_s_const", int'(s), 0);

        applyStimulus(1, 1, 1, 0, 0, 1, "half11");
        checkOutput("half11_c_const", int'(c), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, "half00");
        applyStimulus(1, 0, 1, 0, 0, 1, "half01");
        applyStimulus(1, 1, 0, 0, 0, 1, "half10");

        // 3 + 3 LSB first, with an idle gap while the carry is pending.
        serial_sum = 0;
        applyStimulus(1, 1, 1, 1, 1, 1, "ser0");
        serial_sum += int'(s);
        applyStimulus(1, 1, 1, 1, 0, 1, "ser1");
        serial_sum += int'(s) * 2;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 1, "hold");
        checkOutput("hold_state_const", int'(carry_state), 1);
        applyStimulus(1, 0, 0, 1, 0, 1, "ser2");
        serial_sum += int'(s) * 4;
        checkOutput("serial_3p3", serial_sum, 6);

        applyStimulus(1, 1, 1, 1, 1, 1, "ovr_prep");
        applyStimulus(1, 1, 0, 1, 1, 1, "ovr");
        checkOutput("ovr_cnt_const", int'(bit_cnt), 1);

        applyStimulus(1, 1, 0, 1, 1, 1, "wrap0");
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 1, 0, 1, "wrap");
        checkOutput("wrap_cnt_const", int'(bit_cnt), 1);
        applyStimulus(1, 1, 1, 1, 0, 0, "mid_reset");

        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            ai = $urandom_range(0, 1);
            bi = $urandom_range(0, 1);
            md = ($urandom_range(0, 9) < 8) ? 1 : 0;
            cc = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rn = ($urandom_range(0, 49) == 0) ? 0 : 1;
            applyStimulus(v[0], ai[0], bi[0], md[0], cc[0], rn[0], "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
